// File: rtl/tb_axi_dma_pkg.sv
// Shared types and AXI constants for the simulation-top AXI4 DMA master.
package tb_axi_dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AW,
        ST_W,
        ST_B,
        ST_AR,
        ST_R,
        ST_DONE
    } dma_state_e;

    localparam logic [2:0] AXI_SIZE_64B   = 3'b110;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [3:0] AXI_CACHE_DEF  = 4'b0011;
    localparam int         BEAT_BYTES     = 64;
    localparam int         BEAT_SHIFT     = $clog2(BEAT_BYTES);

endpackage

// File: rtl/tb_axi_dma_if.sv
// Full AXI4 bus between the DMA master and the BRAM memory model.
interface tb_axi_dma_if #(
    parameter int ID_W   = 4,
    parameter int DATA_W = 512,
    parameter int ADDR_W = 26
);
    logic [ID_W-1:0]     awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awlock;
    logic [3:0]          awcache;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;

    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;

    logic [ID_W-1:0]     bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    logic [ID_W-1:0]     arid;
    logic [ADDR_W-1:0]   araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arlock;
    logic [3:0]          arcache;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;

    logic [ID_W-1:0]     rid;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

endinterface

// File: rtl/tb_axi_dma_beat_cnt.sv
// Beats-remaining counter shared by the W and R data phases; is_last flags the final beat.
module tb_axi_dma_beat_cnt (
    input  logic       s_axi_aclk,
    input  logic       s_axi_aresetn,
    input  logic       i_load,
    input  logic [7:0] i_load_val,
    input  logic       i_dec,
    output logic [7:0] o_cnt,
    output logic       o_is_last
);
    logic [7:0] r_cnt;

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != 8'd0)) begin
            r_cnt <= r_cnt - 8'd1;
        end
    end

    assign o_cnt     = r_cnt;
    assign o_is_last = (r_cnt == 8'd0);

endmodule

// File: rtl/tb_axi_dma_master.sv
// Single-outstanding AXI4 master turning command/stream requests into 64 B INCR bursts.
// Optional TB_AXI_DMA_RLAST_CHECK_EN: flag rlast that disagrees with the beat counter.
module tb_axi_dma_master
    import tb_axi_dma_pkg::*;
#(
    parameter int C_M_AXI_ID_WIDTH   = 4,
    parameter int C_M_AXI_DATA_WIDTH = 512,
    parameter int C_M_AXI_ADDR_WIDTH = 26
) (
    input  logic                            s_axi_aclk,
    input  logic                            s_axi_aresetn,

    input  logic                            i_cmd_valid,
    output logic                            o_cmd_ready,
    input  logic                            i_cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   i_cmd_addr,
    input  logic [7:0]                      i_cmd_len,

    input  logic                            i_wd_valid,
    output logic                            o_wd_ready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   i_wd_data,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0] i_wd_strb,

    output logic                            o_rd_valid,
    input  logic                            i_rd_ready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   o_rd_data,
    output logic                            o_rd_last,

    output logic                            o_done_valid,
    output logic                            o_done_write,
    output logic                            o_done_err,

    tb_axi_dma_if.master                    m_axi
);
    localparam logic [C_M_AXI_ADDR_WIDTH-1:0] ADDR_MASK =
        {{(C_M_AXI_ADDR_WIDTH-BEAT_SHIFT){1'b1}}, {BEAT_SHIFT{1'b0}}};

    dma_state_e                      r_state;
    logic                            r_cmd_ready;
    logic                            r_awvalid;
    logic                            r_arvalid;
    logic                            r_bready;
    logic                            r_done_valid;
    logic                            r_write;
    logic                            r_err;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   r_addr;
    logic [7:0]                      r_len;

    logic                            w_accept;
    logic                            w_w_hs;
    logic                            w_r_hs;
    logic                            w_is_last;
    logic                            w_rlast_err;
    logic [7:0]                      w_cnt;
    logic                            w_unused;

    assign w_accept = (r_state == ST_IDLE) && i_cmd_valid;
    assign w_w_hs   = (r_state == ST_W) && i_wd_valid && m_axi.wready;
    assign w_r_hs   = (r_state == ST_R) && m_axi.rvalid && i_rd_ready;

`ifdef TB_AXI_DMA_RLAST_CHECK_EN
    assign w_rlast_err = w_r_hs && (m_axi.rlast != w_is_last);
`else
    assign w_rlast_err = 1'b0;
`endif

    tb_axi_dma_beat_cnt u_beat_cnt (
        .s_axi_aclk    (s_axi_aclk),
        .s_axi_aresetn (s_axi_aresetn),
        .i_load        (w_accept),
        .i_load_val    (i_cmd_len),
        .i_dec         (w_w_hs || w_r_hs),
        .o_cnt         (w_cnt),
        .o_is_last     (w_is_last)
    );

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_state      <= ST_IDLE;
            r_cmd_ready  <= 1'b1;
            r_awvalid    <= 1'b0;
            r_arvalid    <= 1'b0;
            r_bready     <= 1'b0;
            r_done_valid <= 1'b0;
            r_write      <= 1'b0;
            r_err        <= 1'b0;
            r_addr       <= '0;
            r_len        <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_cmd_valid) begin
                        r_addr      <= i_cmd_addr & ADDR_MASK;
                        r_len       <= i_cmd_len;
                        r_write     <= i_cmd_write;
                        r_err       <= 1'b0;
                        r_cmd_ready <= 1'b0;
                        if (i_cmd_write) begin
                            r_awvalid <= 1'b1;
                            r_state   <= ST_AW;
                        end else begin
                            r_arvalid <= 1'b1;
                            r_state   <= ST_AR;
                        end
                    end
                end
                ST_AW: begin
                    if (m_axi.awready) begin
                        r_awvalid <= 1'b0;
                        r_state   <= ST_W;
                    end
                end
                ST_W: begin
                    if (w_w_hs && w_is_last) begin
                        r_bready <= 1'b1;
                        r_state  <= ST_B;
                    end
                end
                ST_B: begin
                    if (m_axi.bvalid) begin
                        r_err        <= r_err | m_axi.bresp[1];
                        r_bready     <= 1'b0;
                        r_done_valid <= 1'b1;
                        r_state      <= ST_DONE;
                    end
                end
                ST_AR: begin
                    if (m_axi.arready) begin
                        r_arvalid <= 1'b0;
                        r_state   <= ST_R;
                    end
                end
                ST_R: begin
                    if (w_r_hs) begin
                        r_err <= r_err | m_axi.rresp[1] | w_rlast_err;
`ifdef TB_AXI_DMA_RLAST_CHECK_EN
                        if (w_rlast_err) begin
                            $error("tb_axi_dma_master: rlast mismatch addr=%h cnt=%0d", r_addr, w_cnt);
                        end
`endif
                        if (w_is_last) begin
                            r_done_valid <= 1'b1;
                            r_state      <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    r_done_valid <= 1'b0;
                    r_cmd_ready  <= 1'b1;
                    r_state      <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_cmd_ready  = r_cmd_ready;
    assign o_done_valid = r_done_valid;
    assign o_done_write = r_write;
    assign o_done_err   = r_err;

    assign m_axi.awid    = '0;
    assign m_axi.awaddr  = r_addr;
    assign m_axi.awlen   = r_len;
    assign m_axi.awsize  = AXI_SIZE_64B;
    assign m_axi.awburst = AXI_BURST_INCR;
    assign m_axi.awlock  = 1'b0;
    assign m_axi.awcache = AXI_CACHE_DEF;
    assign m_axi.awprot  = '0;
    assign m_axi.awvalid = r_awvalid;

    // Write and read data are pure pass-through while the matching data phase is active.
    assign m_axi.wvalid  = (r_state == ST_W) && i_wd_valid;
    assign o_wd_ready    = (r_state == ST_W) && m_axi.wready;
    assign m_axi.wdata   = i_wd_data;
    assign m_axi.wstrb   = i_wd_strb;
    assign m_axi.wlast   = (r_state == ST_W) && w_is_last;

    assign m_axi.bready  = r_bready;

    assign m_axi.arid    = '0;
    assign m_axi.araddr  = r_addr;
    assign m_axi.arlen   = r_len;
    assign m_axi.arsize  = AXI_SIZE_64B;
    assign m_axi.arburst = AXI_BURST_INCR;
    assign m_axi.arlock  = 1'b0;
    assign m_axi.arcache = AXI_CACHE_DEF;
    assign m_axi.arprot  = '0;
    assign m_axi.arvalid = r_arvalid;

    assign o_rd_valid    = (r_state == ST_R) && m_axi.rvalid;
    assign m_axi.rready  = (r_state == ST_R) && i_rd_ready;
    assign o_rd_data     = m_axi.rdata;
    assign o_rd_last     = (r_state == ST_R) && w_is_last;

    assign w_unused = &{1'b0, m_axi.bid, m_axi.bresp[0], m_axi.rid, m_axi.rresp[0],
                        m_axi.rlast, w_cnt};

endmodule
